// File: rtl/pc_redirect_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pc_redirect_ctrl_pkg
//
// Shared definitions for the front-end redirect controller:
//   - rd_state_t     : controller state encoding
//   - rd_src_t       : which redirect source won arbitration in a cycle
//   - FLUSH_IF/ALL   : flush class attached to a redirect
//   - RESET_PC       : boot PC, shared with the PC register
//   - next_insn_pc() : PC of the sequentially following instruction
// ---------------------------------------------------------------------------
package pc_redirect_ctrl_pkg;

    // Boot address; the PC register uses the same constant.
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    // Flush class: FLUSH_IF squashes only IF/ID (decode-stage redirect),
    // FLUSH_ALL squashes both IF/ID and ID/EX.
    localparam logic FLUSH_IF  = 1'b0;
    localparam logic FLUSH_ALL = 1'b1;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PENDING      = 3'd1,
        FENCE_DRAIN  = 3'd2,
        FENCE_INV    = 3'd3,
        FENCE_RESUME = 3'd4
    } rd_state_t;

    typedef enum logic [2:0] {
        SRC_NONE       = 3'd0,
        SRC_TRAP       = 3'd1,
        SRC_MISPREDICT = 3'd2,
        SRC_BRANCH     = 3'd3,
        SRC_FENCE      = 3'd4,
        SRC_EARLY_JUMP = 3'd5
    } rd_src_t;

    // Address of the next sequential 32-bit instruction; wraps mod 2^32.
    function automatic logic [31:0] next_insn_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pc_redirect_ctrl_prio_mux.sv
// ---------------------------------------------------------------------------
// redirect_prio_mux
//
// Combinational priority encoder over the five redirect sources.
// Priority, highest first: trap > mispredict > branch > fence.i > early jump.
//
// Ports:
//   trap_valid/trap_target             : CSR trap or xRET
//   mispredict_valid/mispredict_pc     : wrong path, restart at pc + 4
//   branch_valid/branch_target         : resolved EX branch/jump
//   fence_i_valid/fence_pc             : fence.i, resume at fence_pc + 4
//   early_jump_valid/early_jump_target : decode-stage jump
//   hit                                : some source is requesting
//   target                             : winning target address
//   flush_class                        : FLUSH_IF or FLUSH_ALL for the winner
//   src                                : identity of the winner
// ---------------------------------------------------------------------------
module redirect_prio_mux
    import pc_redirect_ctrl_pkg::*;
(
    input  logic        trap_valid,
    input  logic [31:0] trap_target,
    input  logic        mispredict_valid,
    input  logic [31:0] mispredict_pc,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    input  logic        fence_i_valid,
    input  logic [31:0] fence_pc,
    input  logic        early_jump_valid,
    input  logic [31:0] early_jump_target,
    output logic        hit,
    output logic [31:0] target,
    output logic        flush_class,
    output rd_src_t     src
);

    always_comb begin
        hit         = 1'b1;
        target      = '0;
        flush_class = FLUSH_IF;
        src         = SRC_NONE;
        if (trap_valid) begin
            target      = trap_target;
            flush_class = FLUSH_ALL;
            src         = SRC_TRAP;
        end else if (mispredict_valid) begin
            target      = next_insn_pc(mispredict_pc);
            flush_class = FLUSH_ALL;
            src         = SRC_MISPREDICT;
        end else if (branch_valid) begin
            target      = branch_target;
            flush_class = FLUSH_ALL;
            src         = SRC_BRANCH;
        end else if (fence_i_valid) begin
            // Fence resumes at the following instruction; flushes are
            // sequenced by the FSM, so the class here is informational.
            target      = next_insn_pc(fence_pc);
            flush_class = FLUSH_ALL;
            src         = SRC_FENCE;
        end else if (early_jump_valid) begin
            // Jump is still in decode, so only IF/ID holds wrong-path work.
            target      = early_jump_target;
            flush_class = FLUSH_IF;
            src         = SRC_EARLY_JUMP;
        end else begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// pc_redirect_ctrl
//
// Front-end redirect controller. Arbitrates all PC redirect sources, holds a
// redirect that arrives while fetch is stalled, and sequences fence.i
// (drain -> I-cache invalidate -> resume).
//
// Ports:
//   clk, rst                        : clock, async active-high reset
//   trap_*, mispredict_*, branch_*,
//   early_jump_*, fence_i_valid,
//   fence_pc                        : redirect requests
//   pipe_empty                      : no outstanding MEM/WB stores
//   stall_fetch                     : fetch cannot accept a new PC
//   icache_inv_done                 : invalidate complete pulse
//   redirect_valid/redirect_pc      : registered PC load command
//   flush_if_id, flush_id_ex        : pipeline register squash strobes
//   fetch_hold                      : PC must not advance
//   icache_inv_req                  : level invalidate request
//   busy                            : controller not in IDLE
// ---------------------------------------------------------------------------
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        trap_valid,
    input  logic [31:0] trap_target,
    input  logic        mispredict_valid,
    input  logic [31:0] mispredict_pc,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    input  logic        early_jump_valid,
    input  logic [31:0] early_jump_target,
    input  logic        fence_i_valid,
    input  logic [31:0] fence_pc,
    input  logic        pipe_empty,
    input  logic        stall_fetch,
    input  logic        icache_inv_done,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        fetch_hold,
    output logic        icache_inv_req,
    output logic        busy
);

    rd_state_t   state;
    logic [31:0] pend_target;
    logic        pend_class;
    logic [31:0] fence_target;

    logic        win_hit;
    logic [31:0] win_target;
    logic        win_class;
    rd_src_t     win_src;
    logic        win_strong;
    logic [31:0] pend_target_now;
    logic        pend_class_now;

    redirect_prio_mux u_prio (
        .trap_valid        (trap_valid),
        .trap_target       (trap_target),
        .mispredict_valid  (mispredict_valid),
        .mispredict_pc     (mispredict_pc),
        .branch_valid      (branch_valid),
        .branch_target     (branch_target),
        .fence_i_valid     (fence_i_valid),
        .fence_pc          (fence_pc),
        .early_jump_valid  (early_jump_valid),
        .early_jump_target (early_jump_target),
        .hit               (win_hit),
        .target            (win_target),
        .flush_class       (win_class),
        .src               (win_src)
    );

    // Sources allowed to overwrite a pending redirect: anything from EX/MEM
    // or the CSR unit. Early jumps and fence.i lose to the pending flush.
    assign win_strong = win_hit && ((win_src == SRC_TRAP) ||
                                    (win_src == SRC_MISPREDICT) ||
                                    (win_src == SRC_BRANCH));

    // Latched redirect as it stands this cycle, including a same-cycle
    // overwrite, so a stronger request on the release edge is not lost.
    assign pend_target_now = win_strong ? win_target : pend_target;
    assign pend_class_now  = win_strong ? win_class  : pend_class;

    // Hold/request/busy are pure decodes of the state register, so they
    // change only on a clock edge and fall immediately on async reset.
    assign fetch_hold     = (state == PENDING) || (state == FENCE_DRAIN) ||
                            (state == FENCE_INV);
    assign icache_inv_req = (state == FENCE_INV);
    assign busy           = (state != IDLE);

    // Main controller: one-cycle strobes default low each cycle, redirect_pc
    // keeps its last value between redirects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
            redirect_pc    <= RESET_PC;
            flush_if_id    <= 1'b0;
            flush_id_ex    <= 1'b0;
            pend_target    <= '0;
            pend_class     <= FLUSH_IF;
            fence_target   <= '0;
        end else begin
            redirect_valid <= 1'b0;
            flush_if_id    <= 1'b0;
            flush_id_ex    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (win_hit) begin
                        if (win_src == SRC_FENCE) begin
                            fence_target <= win_target;
                            flush_if_id  <= 1'b1;
                            state        <= FENCE_DRAIN;
                        end else if (stall_fetch) begin
                            pend_target <= win_target;
                            pend_class  <= win_class;
                            state       <= PENDING;
                        end else begin
                            redirect_valid <= 1'b1;
                            redirect_pc    <= win_target;
                            flush_if_id    <= 1'b1;
                            flush_id_ex    <= (win_class == FLUSH_ALL);
                        end
                    end
                end

                PENDING: begin
                    if (win_strong) begin
                        pend_target <= win_target;
                        pend_class  <= win_class;
                    end
                    if (!stall_fetch) begin
                        redirect_valid <= 1'b1;
                        redirect_pc    <= pend_target_now;
                        flush_if_id    <= 1'b1;
                        flush_id_ex    <= (pend_class_now == FLUSH_ALL);
                        state          <= IDLE;
                    end
                end

                FENCE_DRAIN, FENCE_INV, FENCE_RESUME: begin
                    // A trap aborts the fence outright; the fence target is
                    // dropped and software re-executes fence.i after the
                    // handler. All other sources are ignored while fencing.
                    if (win_src == SRC_TRAP) begin
                        fence_target <= '0;
                        if (stall_fetch) begin
                            pend_target <= win_target;
                            pend_class  <= win_class;
                            state       <= PENDING;
                        end else begin
                            redirect_valid <= 1'b1;
                            redirect_pc    <= win_target;
                            flush_if_id    <= 1'b1;
                            flush_id_ex    <= 1'b1;
                            state          <= IDLE;
                        end
                    end else if (state == FENCE_DRAIN) begin
                        if (pipe_empty) begin
                            state <= FENCE_INV;
                        end
                    end else if (state == FENCE_INV) begin
                        if (icache_inv_done) begin
                            state <= FENCE_RESUME;
                        end
                    end else begin
                        if (!stall_fetch) begin
                            redirect_valid <= 1'b1;
                            redirect_pc    <= fence_target;
                            flush_if_id    <= 1'b1;
                            flush_id_ex    <= 1'b1;
                            state          <= IDLE;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_redirect_ctrl
//
// Scoreboard bench: each scenario pushes the redirects it expects, and a
// negedge monitor pops and compares every redirect_valid the DUT produces.
// Status outputs are compared directly at chosen points.
// ---------------------------------------------------------------------------
module tb_pc_redirect_ctrl;

    typedef struct {
        logic [31:0] pc;
        logic        fi;
        logic        fe;
    } exp_t;

    localparam int SRC_TRAP = 0;
    localparam int SRC_MISP = 1;
    localparam int SRC_BR   = 2;
    localparam int SRC_EJ   = 3;
    localparam int SRC_FNC  = 4;

    logic        clk;
    logic        rst;
    logic        trap_valid;
    logic [31:0] trap_target;
    logic        mispredict_valid;
    logic [31:0] mispredict_pc;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        early_jump_valid;
    logic [31:0] early_jump_target;
    logic        fence_i_valid;
    logic [31:0] fence_pc;
    logic        pipe_empty;
    logic        stall_fetch;
    logic        icache_inv_done;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        fetch_hold;
    logic        icache_inv_req;
    logic        busy;

    exp_t sbq[$];
    int   checkCount = 0;
    int   passCount  = 0;

    pc_redirect_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .trap_valid        (trap_valid),
        .trap_target       (trap_target),
        .mispredict_valid  (mispredict_valid),
        .mispredict_pc     (mispredict_pc),
        .branch_valid      (branch_valid),
        .branch_target     (branch_target),
        .early_jump_valid  (early_jump_valid),
        .early_jump_target (early_jump_target),
        .fence_i_valid     (fence_i_valid),
        .fence_pc          (fence_pc),
        .pipe_empty        (pipe_empty),
        .stall_fetch       (stall_fetch),
        .icache_inv_done   (icache_inv_done),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .flush_if_id       (flush_if_id),
        .flush_id_ex       (flush_id_ex),
        .fetch_hold        (fetch_hold),
        .icache_inv_req    (icache_inv_req),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        else
            passCount++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearRequests();
        trap_valid       = 1'b0;
        mispredict_valid = 1'b0;
        branch_valid     = 1'b0;
        early_jump_valid = 1'b0;
        fence_i_valid    = 1'b0;
        icache_inv_done  = 1'b0;
    endtask

    task automatic applyStimulus(input int src, input logic [31:0] addr);
        case (src)
            SRC_TRAP: begin trap_valid = 1'b1;       trap_target = addr;       end
            SRC_MISP: begin mispredict_valid = 1'b1; mispredict_pc = addr;     end
            SRC_BR:   begin branch_valid = 1'b1;     branch_target = addr;     end
            SRC_EJ:   begin early_jump_valid = 1'b1; early_jump_target = addr; end
            default:  begin fence_i_valid = 1'b1;    fence_pc = addr;          end
        endcase
    endtask

    task automatic pushExpect(input logic [31:0] pc, input logic fi, input logic fe);
        exp_t e;
        e.pc = pc;
        e.fi = fi;
        e.fe = fe;
        sbq.push_back(e);
    endtask

    task automatic finishScenario(input string tag);
        tick();
        tick();
        checkOutput(tag, 32'(sbq.size()), 32'd0);
    endtask

    // Redirect monitor: every redirect pulse must match the next expectation.
    always @(negedge clk) begin
        if (!rst && redirect_valid) begin
            checkOutput("redirect_expected", 32'(sbq.size() != 0), 32'd1);
            if (sbq.size() != 0) begin
                exp_t e;
                e = sbq.pop_front();
                checkOutput("redirect_pc", redirect_pc, e.pc);
                checkOutput("redirect_flush_if", 32'(flush_if_id), 32'(e.fi));
                checkOutput("redirect_flush_ex", 32'(flush_id_ex), 32'(e.fe));
            end
        end
    end

    initial begin
        rst = 1'b1;
        trap_target = '0;
        mispredict_pc = '0;
        branch_target = '0;
        early_jump_target = '0;
        fence_pc = '0;
        pipe_empty = 1'b0;
        stall_fetch = 1'b0;
        clearRequests();

        // Reset values
        #3;
        checkOutput("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        checkOutput("rst_redirect_pc", redirect_pc, 32'h8000_0000);
        checkOutput("rst_flush_if", 32'(flush_if_id), 32'd0);
        checkOutput("rst_flush_ex", 32'(flush_id_ex), 32'd0);
        checkOutput("rst_fetch_hold", 32'(fetch_hold), 32'd0);
        checkOutput("rst_inv_req", 32'(icache_inv_req), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Branch and early jump together: branch wins, both flushes
        applyStimulus(SRC_BR, 32'h8000_0100);
        applyStimulus(SRC_EJ, 32'h8000_0200);
        pushExpect(32'h8000_0100, 1'b1, 1'b1);
        tick();
        clearRequests();
        finishScenario("br_ej_done");

        // Early jump alone: IF/ID flush only
        applyStimulus(SRC_EJ, 32'h8000_0300);
        pushExpect(32'h8000_0300, 1'b1, 1'b0);
        tick();
        clearRequests();
        finishScenario("ej_done");

        // Mispredict at top of address space wraps to zero
        applyStimulus(SRC_MISP, 32'hFFFF_FFFC);
        pushExpect(32'h0000_0000, 1'b1, 1'b1);
        tick();
        clearRequests();
        finishScenario("misp_wrap_done");

        // Branch while stalled, overwritten by a trap mid-stall
        stall_fetch = 1'b1;
        applyStimulus(SRC_BR, 32'h8000_0040);
        tick();
        clearRequests();
        checkOutput("stall_hold_1", 32'(fetch_hold), 32'd1);
        checkOutput("stall_busy", 32'(busy), 32'd1);
        applyStimulus(SRC_TRAP, 32'h8000_1000);
        tick();
        clearRequests();
        checkOutput("stall_hold_2", 32'(fetch_hold), 32'd1);
        tick();
        checkOutput("stall_hold_3", 32'(fetch_hold), 32'd1);
        checkOutput("stall_no_redirect", 32'(redirect_valid), 32'd0);
        stall_fetch = 1'b0;
        pushExpect(32'h8000_1000, 1'b1, 1'b1);
        tick();
        checkOutput("stall_release_hold", 32'(fetch_hold), 32'd0);
        finishScenario("stall_done");

        // Full fence.i sequence
        applyStimulus(SRC_FNC, 32'h8000_0010);
        tick();
        clearRequests();
        checkOutput("fence_entry_flush_if", 32'(flush_if_id), 32'd1);
        checkOutput("fence_entry_flush_ex", 32'(flush_id_ex), 32'd0);
        checkOutput("fence_entry_no_redirect", 32'(redirect_valid), 32'd0);
        checkOutput("fence_drain_hold", 32'(fetch_hold), 32'd1);
        icache_inv_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            icache_inv_done = 1'b0;
            checkOutput("fence_drain_no_inv", 32'(icache_inv_req), 32'd0);
            checkOutput("fence_drain_busy", 32'(busy), 32'd1);
        end
        pipe_empty = 1'b1;
        tick();
        pipe_empty = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("fence_inv_req", 32'(icache_inv_req), 32'd1);
            checkOutput("fence_inv_hold", 32'(fetch_hold), 32'd1);
            tick();
        end
        icache_inv_done = 1'b1;
        pushExpect(32'h8000_0014, 1'b1, 1'b1);
        tick();
        icache_inv_done = 1'b0;
        checkOutput("fence_resume_no_inv", 32'(icache_inv_req), 32'd0);
        checkOutput("fence_resume_busy", 32'(busy), 32'd1);
        tick();
        checkOutput("fence_done_busy", 32'(busy), 32'd0);
        finishScenario("fence_done");

        // Trap aborts fence in FENCE_INV; fence target never issued
        pipe_empty = 1'b1;
        applyStimulus(SRC_FNC, 32'h8000_0020);
        tick();
        clearRequests();
        tick();
        pipe_empty = 1'b0;
        checkOutput("abort_inv_req_before", 32'(icache_inv_req), 32'd1);
        applyStimulus(SRC_TRAP, 32'h8000_2000);
        pushExpect(32'h8000_2000, 1'b1, 1'b1);
        tick();
        clearRequests();
        checkOutput("abort_inv_req_after", 32'(icache_inv_req), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        icache_inv_done = 1'b1;
        tick();
        icache_inv_done = 1'b0;
        tick();
        tick();
        finishScenario("abort_done");

        // Reset pulse in FENCE_DRAIN
        applyStimulus(SRC_FNC, 32'h8000_0030);
        tick();
        clearRequests();
        checkOutput("rstmid_busy_before", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstmid_busy", 32'(busy), 32'd0);
        checkOutput("rstmid_hold", 32'(fetch_hold), 32'd0);
        checkOutput("rstmid_inv_req", 32'(icache_inv_req), 32'd0);
        checkOutput("rstmid_redirect_pc", redirect_pc, 32'h8000_0000);
        checkOutput("rstmid_redirect_valid", 32'(redirect_valid), 32'd0);
        tick();
        rst = 1'b0;
        pipe_empty = 1'b1;
        tick();
        icache_inv_done = 1'b1;
        tick();
        icache_inv_done = 1'b0;
        pipe_empty = 1'b0;
        checkOutput("rstmid_idle_after", 32'(busy), 32'd0);
        finishScenario("rstmid_done");

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
